// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1
// framing with a parity check and a live parity_err output.
module uart_rx #(
    parameter int TICK_DIV = 163
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] tick_cnt_q;
    logic          tick;
    logic [3:0]    s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    assign tick = (tick_cnt_q == TICK_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            sh_q       <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            sh_q       <= sh_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = brk_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd15) begin
                        sh_d = {rx_s_q, sh_q[7:1]};
                        n_d  = n_q + 3'd1;
                        if (n_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd15) begin
                        par_d   = rx_s_q;
                        state_d = STOP;
                    end
                end
            end
`endif
            STOP: begin
                // After a framing error the line may be held in break; wait for idle high.
                if (brk_q) begin
                    if (rx_s_q) begin
                        brk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd15) begin
                        if (!rx_s_q) begin
                            ferr_d = 1'b1;
                            brk_d  = 1'b1;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            if (par_q != ^sh_q) begin
                                perr_d = 1'b1;
                            end else
`endif
                            begin
                                data_d = sh_q;
                                done_d = 1'b1;
                            end
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at TICK_DIV=4 (one bit = 64 clk); covers 8E1 when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int TDIV = 4;
    localparam int BIT  = 16 * TDIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;

    uart_rx #(.TICK_DIV(TDIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         cyc      = 0;
    int         done_cyc = -1;
    int         start_cyc;
    logic [7:0] log_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are counted per cycle, so a pulse stuck for two clocks counts twice.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            log_q.push_back(rx_data);
            done_cyc = cyc;
        end
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic b);
        rx = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_bit);
        logic [10:0] fr;
        fr = PAR_EN ? {stop_v, par_bit, d, 1'b0} : {1'b1, stop_v, d, 1'b0};
        for (int i = 0; i < (PAR_EN ? 11 : 10); i++) bit_time(fr[i]);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_done", {31'd0, rx_done}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // 0xA5, stop sample lands 607..611 clk after the falling edge
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        bit_time(1'b1);
        chk("a5_cnt",  done_cnt, 1);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_lat",  {31'd0, ((done_cyc - start_cyc) >= 607) && ((done_cyc - start_cyc) <= 612)}, 32'd1);
        chk("a5_ferr", ferr_cnt, 0);

        // start-bit glitch of 5 ticks
        rx = 1'b0;
        repeat (5 * TDIV) @(posedge clk);
        #1;
        bit_time(1'b1);
        bit_time(1'b1);
        chk("gl_done", done_cnt, 1);
        chk("gl_ferr", ferr_cnt, 0);

        send_frame(8'h3C, 1'b1, ^8'h3C);
        bit_time(1'b1);
        chk("3c_cnt",  done_cnt, 2);
        chk("3c_data", {24'd0, rx_data}, 32'h3C);

        // 0x81 with low stop bit, then the line held in break
        send_frame(8'h81, 1'b0, ^8'h81);
        bit_time(1'b0);
        bit_time(1'b0);
        chk("fe_ferr", ferr_cnt, 1);
        chk("fe_done", done_cnt, 2);
        chk("fe_data", {24'd0, rx_data}, 32'h3C);
        bit_time(1'b1);
        bit_time(1'b1);
        bit_time(1'b1);
        chk("fe_norearm_done", done_cnt, 2);
        chk("fe_norearm_ferr", ferr_cnt, 1);

        // back-to-back frames, no idle between stop and next start
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        bit_time(1'b1);
        chk("b2b_cnt",  done_cnt, 4);
        chk("b2b_d0",   {24'd0, log_q[2]}, 32'h00);
        chk("b2b_d1",   {24'd0, log_q[3]}, 32'hFF);
        chk("b2b_data", {24'd0, rx_data}, 32'hFF);

        // reset in the middle of bit 4 of 0x55
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(i[0] ? 1'b0 : 1'b1);
        rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mr_data_rst", {24'd0, rx_data}, 32'h00);
        reset = 1'b0;
        bit_time(1'b1);
        bit_time(1'b1);
        bit_time(1'b1);
        chk("mr_done", done_cnt, 4);
        chk("mr_ferr", ferr_cnt, 1);
        send_frame(8'h12, 1'b1, ^8'h12);
        bit_time(1'b1);
        chk("mr_12_cnt",  done_cnt, 5);
        chk("mr_12_data", {24'd0, rx_data}, 32'h12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        bit_time(1'b1);
        chk("par_bad_perr", perr_cnt, 1);
        chk("par_bad_done", done_cnt, 5);
        chk("par_bad_data", {24'd0, rx_data}, 32'h12);
        send_frame(8'h07, 1'b1, 1'b1);
        bit_time(1'b1);
        chk("par_ok_done", done_cnt, 6);
        chk("par_ok_data", {24'd0, rx_data}, 32'h07);
        chk("par_ok_perr", perr_cnt, 1);
`else
        chk("no_par_perr", perr_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL take parameter TICK_DIV, default 163, meaning clk cycles per 16x-oversample tick (50 MHz / (19200*16)).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all logic rises on posedge clk.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port rx, input, 1 bit, the asynchronous serial line, idle high.
REQ-005 The block SHALL have port rx_data, output, 8 bits, the last correctly received byte; it feeds the receive buffer w_data.
REQ-006 The block SHALL have port rx_done, output, 1 bit, a one-cycle pulse per valid byte; it feeds the receive buffer wr.
REQ-007 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port parity_err, output, 1 bit, a one-cycle pulse on parity mismatch; it is tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-009 rx SHALL pass through a 2-FF synchronizer (rx_s) before any use; both FFs are 1 after reset.
REQ-010 A free-running tick counter SHALL count 0..TICK_DIV-1, wrap to 0 and assert internal tick for one clk at TICK_DIV-1.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-012 IDLE: on rx_s==0, go to START and clear the sample counter s (4 bits).
REQ-013 START: count ticks; at s==7 (mid start bit), go to DATA if rx_s==0, else return to IDLE as a glitch with no outputs.
REQ-014 DATA: sample rx_s every 16 ticks into a shift register, LSB first; after the 8th bit, go to PARITY or STOP.
REQ-015 PARITY: sample after 16 ticks and compare with the even parity of the 8 data bits.
REQ-016 STOP: sample after 16 ticks; if rx_s==1, load rx_data, pulse rx_done on the next clk and go to IDLE.
REQ-017 STOP with sample 0 SHALL pulse frame_err, leave rx_data unchanged, suppress rx_done, and hold in STOP until rx_s==1 before entering IDLE, so a break causes no retrigger.
REQ-018 On parity mismatch with a good stop bit, the block SHALL pulse parity_err, suppress rx_done and leave rx_data unchanged.
REQ-019 rx_done, frame_err and parity_err SHALL be mutually exclusive and each high for exactly one clk per frame.
REQ-020 A new start bit SHALL be accepted in the clk immediately after the STOP-to-IDLE transition, so back-to-back frames with no idle gap are received.
REQ-021 rx_data SHALL be stable from the rx_done pulse until the next valid frame.

Reset
REQ-022 While reset is high: state=IDLE, tick counter=0, s=0, shift register=0, rx_data=0x00, rx_done=0, frame_err=0, parity_err=0, synchronizer=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame without any pulse; reception resumes at the next falling edge after release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN SHALL enable the PARITY state and parity_err, giving an 11-bit frame (8E1); without the macro, the frame is 8N1 and parity_err is constant 0.

Verification
REQ-025 With TICK_DIV=4, send 0xA5 in 8N1 -> rx_data=0xA5 and one rx_done pulse, 1 clk after the stop sample.
REQ-026 Drive rx low for 5 ticks, then high -> no rx_done, no frame_err, FSM back in IDLE.
REQ-027 Receive 0x3C, then send 0x81 with stop bit low -> frame_err pulse, rx_data stays 0x3C, no rx_done until the line goes high.
REQ-028 Send back-to-back 0x00 then 0xFF with zero idle -> two rx_done pulses, rx_data 0x00 then 0xFF.
REQ-029 Assert reset during bit 4 of 0x55, then send 0x12 -> no pulse for the aborted frame; rx_data=0x12 with one rx_done.
REQ-030 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no rx_done; with parity bit 1 -> rx_done and rx_data=0x07.
